// File: rtl/rf_write_arbiter.sv
// Round-robin writeback arbiter for the integer register file's single write
// port, with the per-register busy scoreboard that feeds decode hazard checks.
module rf_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_rd_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_rd_data,
  output logic                        reg_write,
  output logic [ADDR_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  input  logic                        issue_valid,
  input  logic [ADDR_W-1:0]           issue_rd,
  input  logic                        flush,
  output logic [31:0]                 busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  grant_idx_p0;
  logic              grant_any_p0;
  logic [ADDR_W-1:0] sel_addr_p0;
  logic [DATA_W-1:0] sel_data_p0;
  logic [31:0]       busy_nxt;

  // Requester index offset positions past base, wrapping at NUM_REQ.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int offset);
    int s;
    s = int'(base) + offset;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Stage p0: combinational grant search starting at the priority pointer.
  always_comb begin
    grant_idx_p0 = '0;
    grant_any_p0 = 1'b0;
    req_ready    = '0;
    if (!flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_any_p0 && req_valid[wrap_add(ptr, k)]) begin
          grant_any_p0 = 1'b1;
          grant_idx_p0 = wrap_add(ptr, k);
        end
      end
    end
    if (grant_any_p0) req_ready[grant_idx_p0] = 1'b1;
  end

  assign sel_addr_p0 = req_rd_addr[grant_idx_p0*ADDR_W +: ADDR_W];
  assign sel_data_p0 = req_rd_data[grant_idx_p0*DATA_W +: DATA_W];

  // Clear for the committing write is applied first so a same-cycle issue wins.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (reg_write) busy_nxt[rd_addr] = 1'b0;
      if (issue_valid && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Stage p1: registered write port and scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      reg_write <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
      busy      <= '0;
    end else begin
      busy <= busy_nxt;
      if (grant_any_p0) begin
        ptr       <= wrap_add(grant_idx_p0, 1);
        reg_write <= (sel_addr_p0 != '0);
        rd_addr   <= sel_addr_p0;
        rd_data   <= sel_data_p0;
      end else begin
        reg_write <= 1'b0;
      end
    end
  end

endmodule
